// File: rtl/discrete_pkg.sv
// Shared definitions for the discrete audio chain blocks: datapath widths,
// the splitter FSM encoding and the resistive divider gain helper.
package discrete_pkg;

    localparam int DATA_W    = 16;
    localparam int COEF_W    = 17;
    localparam int PROD_W    = DATA_W + COEF_W;
    localparam int MUL_ITERS = COEF_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL0 = 2'd1,
        MUL1 = 2'd2,
        DONE = 2'd3
    } splitter_state_t;

    // Q16 voltage-divider gain rl / (r + rl), truncated. 65536 when r = 0,
    // hence the 17-bit result.
    function automatic logic [COEF_W-1:0] divider_gain_q16(
        input longint unsigned r,
        input longint unsigned rl
    );
        longint unsigned q;
        q = (rl << 16) / (r + rl);
        return q[COEF_W-1:0];
    endfunction

endpackage

// File: rtl/serial_multiplier_16x17.sv
// Serial shift-add multiplier: 16-bit multiplicand times 17-bit multiplier,
// one multiplier bit per clock, LSB first. done is high during the cycle of
// the last iteration, and product already carries that final add, so the
// caller latches the result on the same edge that retires the iteration.
module serial_multiplier_16x17
    import discrete_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] multiplicand,
    input  logic [COEF_W-1:0] multiplier,
    output logic [PROD_W-1:0] product,
    output logic              done
);

    logic [PROD_W-1:0] a_sh;
    logic [COEF_W-1:0] b_sh;
    logic [PROD_W-1:0] acc;
    logic [PROD_W-1:0] partial;
    logic [PROD_W-1:0] acc_next;
    logic [4:0]        cnt;
    logic              running;

    // Partial product for the current multiplier bit and the running sum.
    always_comb begin
        partial  = b_sh[0] ? a_sh : '0;
        acc_next = acc + partial;
        done     = running && (cnt == 5'(MUL_ITERS - 1));
        product  = acc_next;
    end

    // Operand shift registers, accumulator and iteration counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh    <= '0;
            b_sh    <= '0;
            acc     <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            a_sh    <= {{COEF_W{1'b0}}, multiplicand};
            b_sh    <= multiplier;
            acc     <= '0;
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            acc  <= acc_next;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt + 5'd1;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/resistive_two_way_splitter.sv
// One audio sample feeding two resistive divider branches, each loaded to
// ground. Both branch gains are elaboration-time Q16 constants; one serial
// multiplier is time-shared: branch 0 first, then branch 1, then both
// results are published together with a one-cycle out_valid.
module resistive_two_way_splitter
    import discrete_pkg::*;
#(
    parameter int unsigned R0  = 10000,
    parameter int unsigned RL0 = 10000,
    parameter int unsigned R1  = 10000,
    parameter int unsigned RL1 = 10000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] in,
    output logic [DATA_W-1:0] out0,
    output logic [DATA_W-1:0] out1,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun
);

    localparam logic [COEF_W-1:0] G0 = divider_gain_q16(64'(R0), 64'(RL0));
    localparam logic [COEF_W-1:0] G1 = divider_gain_q16(64'(R1), 64'(RL1));

    // Gains never exceed 1.0, so the product shifted down by 16 always fits.
    function automatic logic [DATA_W-1:0] trunc_q16(input logic [PROD_W-1:0] p);
        return DATA_W'(p >> 16);
    endfunction

    splitter_state_t   state;
    splitter_state_t   state_next;
    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] result0;
    logic [DATA_W-1:0] result1;

    logic              mul_start;
    logic [DATA_W-1:0] mul_a;
    logic [COEF_W-1:0] mul_b;
    logic [PROD_W-1:0] mul_product;
    logic              mul_done;

    serial_multiplier_16x17 u_mul (
        .clk          (clk),
        .reset        (reset),
        .start        (mul_start),
        .multiplicand (mul_a),
        .multiplier   (mul_b),
        .product      (mul_product),
        .done         (mul_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: each multiply phase ends on the multiplier's done.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sample_en) state_next = MUL0;
            MUL0:    if (mul_done)  state_next = MUL1;
            MUL1:    if (mul_done)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: multiplier launch and operand/gain mux. The branch 0
    // multiply takes the live input so it can start on the strobe edge;
    // the branch 1 multiply restarts from the captured operand on the
    // edge that retires branch 0.
    always_comb begin
        busy      = (state != IDLE);
        mul_start = 1'b0;
        mul_a     = operand;
        mul_b     = G1;
        case (state)
            IDLE: begin
                mul_start = sample_en;
                mul_a     = in;
                mul_b     = G0;
            end
            MUL0:    mul_start = mul_done;
            default: mul_start = 1'b0;
        endcase
    end

    // Operand capture, per-branch result latches and the published outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            operand   <= '0;
            result0   <= '0;
            result1   <= '0;
            out0      <= '0;
            out1      <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            overrun   <= sample_en && (state != IDLE);
            case (state)
                IDLE: if (sample_en) operand <= in;
                MUL0: if (mul_done)  result0 <= trunc_q16(mul_product);
                MUL1: if (mul_done)  result1 <= trunc_q16(mul_product);
                DONE: begin
                    out0      <= result0;
                    out1      <= result1;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_resistive_two_way_splitter.sv
// Directed bench for resistive_two_way_splitter. Three instances share one
// stimulus: default gains (A), branch 1 at 1/4 (B), branch 0 at unity (C).
module tb_resistive_two_way_splitter;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_en;
    logic [15:0] in_s;

    logic [15:0] out0_a, out1_a, out0_b, out1_b, out0_c, out1_c;
    logic        vld_a, busy_a, ov_a;
    logic        vld_b, busy_b, ov_b;
    logic        vld_c, busy_c, ov_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    resistive_two_way_splitter dut_a (
        .clk(clk), .reset(reset), .sample_en(sample_en), .in(in_s),
        .out0(out0_a), .out1(out1_a), .out_valid(vld_a), .busy(busy_a), .overrun(ov_a)
    );

    resistive_two_way_splitter #(.R0(10000), .RL0(10000), .R1(30000), .RL1(10000)) dut_b (
        .clk(clk), .reset(reset), .sample_en(sample_en), .in(in_s),
        .out0(out0_b), .out1(out1_b), .out_valid(vld_b), .busy(busy_b), .overrun(ov_b)
    );

    resistive_two_way_splitter #(.R0(0), .RL0(10000), .R1(10000), .RL1(10000)) dut_c (
        .clk(clk), .reset(reset), .sample_en(sample_en), .in(in_s),
        .out0(out0_c), .out1(out1_c), .out_valid(vld_c), .busy(busy_c), .overrun(ov_c)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] v, input int unsigned g);
        longint unsigned p;
        p = longint'(v) * longint'(g);
        return 16'(p >> 16);
    endfunction

    function automatic logic [15:0] vec(input int i);
        return 16'(i * 661 + 3);
    endfunction

    // Strobe one sample, expect valid 35 cycles later for one cycle.
    task automatic run_sample(input logic [15:0] v);
        int lat;
        @(negedge clk);
        sample_en = 1'b1;
        in_s      = v;
        @(negedge clk);
        sample_en = 1'b0;
        chk("busy_after_strobe", busy_a, 1);
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (vld_a) begin
                lat = k;
                break;
            end
        end
        chk("latency", lat, 35);
        chk("busy_at_valid", busy_a, 0);
        @(negedge clk);
        chk("valid_width", vld_a, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int ov_cnt, vld_cnt, vld_at, lat, ov_seen;

        // Reset held with a simultaneous strobe: nothing may be captured.
        reset     = 1'b1;
        sample_en = 1'b1;
        in_s      = 16'h8000;
        repeat (3) @(negedge clk);
        reset     = 1'b0;
        sample_en = 1'b0;
        @(negedge clk);
        chk("rst_out0", out0_a, 0);
        chk("rst_out1", out1_a, 0);
        chk("rst_valid", {vld_a, vld_b, vld_c}, 0);
        chk("rst_busy", {busy_a, busy_b, busy_c}, 0);
        chk("rst_overrun", {ov_a, ov_b, ov_c}, 0);

        // Half-scale input through all three gain sets.
        run_sample(16'h8000);
        chk("half_a_out0", out0_a, 16'h4000);
        chk("half_a_out1", out1_a, 16'h4000);
        chk("half_b_out0", out0_b, 16'h4000);
        chk("half_b_out1", out1_b, 16'h2000);
        chk("half_c_out0", out0_c, 16'h8000);
        chk("half_c_out1", out1_c, 16'h4000);

        // Strobe at E0, a rejected strobe at E5, an accepted one at E36.
        @(negedge clk);
        sample_en = 1'b1;
        in_s      = 16'h8000;
        @(negedge clk);
        sample_en = 1'b0;
        ov_cnt  = 0;
        vld_cnt = 0;
        vld_at  = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ov_a) ov_cnt++;
            if (vld_a) begin
                vld_cnt++;
                if (vld_at == 0) vld_at = k;
            end
            if (k == 4) begin
                sample_en = 1'b1;
                in_s      = 16'h1111;
            end
            if (k == 5) begin
                chk("overrun_pulse", ov_a, 1);
                sample_en = 1'b0;
            end
            if (k == 35) begin
                chk("ovr_keep_first_a0", out0_a, 16'h4000);
                chk("ovr_keep_first_b1", out1_b, 16'h2000);
                sample_en = 1'b1;
                in_s      = 16'hFFFF;
            end
            if (k == 36) begin
                sample_en = 1'b0;
                chk("e36_no_overrun", ov_a, 0);
                chk("e36_accepted", busy_a, 1);
            end
        end
        chk("overrun_count", ov_cnt, 1);
        chk("ovr_valid_count", vld_cnt, 1);
        chk("ovr_valid_cycle", vld_at, 35);
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (vld_a) begin
                lat = k + 40;
                break;
            end
        end
        chk("e36_latency", lat, 71);
        chk("full_a_out0", out0_a, 16'h7FFF);
        chk("full_b_out0", out0_b, 16'h7FFF);
        chk("full_b_out1", out1_b, 16'h3FFF);
        chk("full_c_out0", out0_c, 16'hFFFF);
        chk("full_c_out1", out1_c, 16'h7FFF);

        // Reset sampled at E10 aborts the computation.
        @(negedge clk);
        sample_en = 1'b1;
        in_s      = 16'h8000;
        @(negedge clk);
        sample_en = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", busy_a, 0);
        chk("abort_out0", out0_a, 0);
        chk("abort_out1", out1_b, 0);
        chk("abort_c_out0", out0_c, 0);
        vld_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (vld_a || vld_b || vld_c) vld_cnt++;
        end
        chk("abort_no_valid", vld_cnt, 0);

        // Fresh strobes after the abort, unity-gain branch at both extremes.
        run_sample(16'hFFFF);
        chk("unity_max", out0_c, 16'hFFFF);
        run_sample(16'h0000);
        chk("unity_zero", out0_c, 16'h0000);
        chk("zero_b_out1", out1_b, 16'h0000);

        // 100 samples at the minimum 36-cycle period.
        ov_seen = 0;
        @(negedge clk);
        sample_en = 1'b1;
        in_s      = vec(0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            sample_en = 1'b0;
            lat = 0;
            for (int k = 1; k <= 60; k++) begin
                @(negedge clk);
                if (ov_a) ov_seen++;
                if (vld_a) begin
                    lat = k;
                    break;
                end
            end
            chk("b2b_latency", lat, 35);
            chk("b2b_a_out0", out0_a, model(vec(i), 32768));
            chk("b2b_b_out1", out1_b, model(vec(i), 16384));
            chk("b2b_c_out0", out0_c, model(vec(i), 65536));
            if (i < 99) begin
                sample_en = 1'b1;
                in_s      = vec(i + 1);
            end
        end
        chk("b2b_no_overrun", ov_seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
